// File: rtl/backtrack_fifo_lanes_credit_scheduler.sv
// backtrack_fifo_lanes_credit_scheduler: round-robin credit-based scheduler of engine FIFO reads onto lanes
module backtrack_fifo_lanes_credit_scheduler #(
   parameter int NUM_LANES_MAX = 4,
   parameter int CREDIT_MAX = 8,
   localparam int CREDIT_W = $clog2(CREDIT_MAX + 1)
) (
   input  logic                     ap_clk,
   input  logic                     areset,
   input  logic                     configure_route_valid,
   input  logic [NUM_LANES_MAX-1:0] configure_lane_mask,
   input  logic [CREDIT_W-1:0]      configure_credits,
   input  logic                     fifo_response_engine_empty,
   output logic                     fifo_response_engine_rd_en,
   output logic [NUM_LANES_MAX-1:0] grant_lane,
   input  logic [NUM_LANES_MAX-1:0] lane_credit_return,
   input  logic [NUM_LANES_MAX-1:0] lane_prog_full,
   input  logic                     flush,
   output logic                     configure_done,
   output logic                     idle,
   output logic                     credit_overflow
);
   localparam int PTR_W = NUM_LANES_MAX > 1 ? $clog2(NUM_LANES_MAX) : 1;
   typedef enum logic [1:0] {IDLE, CONFIG, RUN, DRAIN} state_t;
   state_t state;
   logic [CREDIT_W-1:0] credit [NUM_LANES_MAX];
   logic [CREDIT_W-1:0] credit_init [NUM_LANES_MAX];
   logic [NUM_LANES_MAX-1:0] mask, prog_full_reg, elig;
   logic [PTR_W-1:0] rr_ptr, g_idx;
   logic [CREDIT_W-1:0] cred_clamp;
   logic found, all_eq;
   assign cred_clamp = configure_credits > CREDIT_W'(CREDIT_MAX) ? CREDIT_W'(CREDIT_MAX) : configure_credits;
   assign configure_done = state == RUN;
   assign idle = state == IDLE;
   always_comb begin
      int idx;
      elig = '0;
      all_eq = 1'b1;
      found = 1'b0;
      g_idx = '0;
      for (int i = 0; i < NUM_LANES_MAX; i++) begin
         elig[i] = mask[i] && credit[i] != '0 && !prog_full_reg[i];
         all_eq = all_eq && credit[i] == credit_init[i];
      end
      // first eligible lane at or after rr_ptr, wrapping upward
      for (int k = 0; k < NUM_LANES_MAX; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_LANES_MAX;
         if (!found && elig[idx]) begin
            found = 1'b1;
            g_idx = PTR_W'(idx);
         end
      end
      fifo_response_engine_rd_en = state == RUN && !fifo_response_engine_empty && found;
      grant_lane = fifo_response_engine_rd_en ? NUM_LANES_MAX'(1) << g_idx : '0;
   end
   always_ff @(posedge ap_clk) begin
      if (areset) begin
         state <= IDLE;
         mask <= '0;
         rr_ptr <= '0;
         prog_full_reg <= '0;
         credit_overflow <= 1'b0;
         for (int i = 0; i < NUM_LANES_MAX; i++) begin
            credit[i] <= '0;
            credit_init[i] <= '0;
         end
      end else begin
         prog_full_reg <= lane_prog_full;
         case (state)
            IDLE: if (configure_route_valid) begin
               state <= CONFIG;
               mask <= configure_lane_mask;
               rr_ptr <= '0;
               for (int i = 0; i < NUM_LANES_MAX; i++) begin
                  credit[i] <= configure_lane_mask[i] ? cred_clamp : '0;
                  credit_init[i] <= configure_lane_mask[i] ? cred_clamp : '0;
               end
            end
            CONFIG: state <= RUN;
            RUN: begin
               if (fifo_response_engine_rd_en) rr_ptr <= PTR_W'((int'(g_idx) + 1) % NUM_LANES_MAX);
               if (flush) state <= DRAIN;
            end
            DRAIN: if (all_eq) state <= IDLE;
            default: state <= IDLE;
         endcase
         if ((state == IDLE || state == CONFIG) && |lane_credit_return) credit_overflow <= 1'b1;
         // a return and a grant on the same lane cancel out
         if (state == RUN || state == DRAIN)
            for (int i = 0; i < NUM_LANES_MAX; i++) begin
               if (lane_credit_return[i] && !grant_lane[i]) begin
                  if (credit[i] >= credit_init[i]) credit_overflow <= 1'b1;
                  else credit[i] <= credit[i] + 1'b1;
               end else if (grant_lane[i] && !lane_credit_return[i]) credit[i] <= credit[i] - 1'b1;
            end
      end
   end
endmodule

// File: tb/tb_backtrack_fifo_lanes_credit_scheduler.sv
// tb_backtrack_fifo_lanes_credit_scheduler: directed vector table plus corner-case sequences
module tb_backtrack_fifo_lanes_credit_scheduler;
   logic ap_clk = 1'b0;
   logic areset = 1'b1;
   logic configure_route_valid = 1'b0;
   logic [3:0] configure_lane_mask = '0;
   logic [3:0] configure_credits = '0;
   logic fifo_response_engine_empty = 1'b1;
   logic fifo_response_engine_rd_en;
   logic [3:0] grant_lane;
   logic [3:0] lane_credit_return = '0;
   logic [3:0] lane_prog_full = '0;
   logic flush = 1'b0;
   logic configure_done, idle, credit_overflow;
   int checks = 0;
   int fails = 0;
   typedef struct {
      logic chk, rst, cv;
      logic [3:0] mask, cred;
      logic emp;
      logic [3:0] ret, pf;
      logic fl, rd;
      logic [3:0] gnt;
      logic dn, id, ov;
   } vec_t;
   vec_t vecs[$];
   always #5 ap_clk = ~ap_clk;
   backtrack_fifo_lanes_credit_scheduler dut (
      .ap_clk(ap_clk),
      .areset(areset),
      .configure_route_valid(configure_route_valid),
      .configure_lane_mask(configure_lane_mask),
      .configure_credits(configure_credits),
      .fifo_response_engine_empty(fifo_response_engine_empty),
      .fifo_response_engine_rd_en(fifo_response_engine_rd_en),
      .grant_lane(grant_lane),
      .lane_credit_return(lane_credit_return),
      .lane_prog_full(lane_prog_full),
      .flush(flush),
      .configure_done(configure_done),
      .idle(idle),
      .credit_overflow(credit_overflow)
   );
   task automatic add(input logic c, r, cv, input logic [3:0] m, cr, input logic e,
                      input logic [3:0] ret, pf, input logic fl, rd, input logic [3:0] g,
                      input logic dn, id, ov);
      vecs.push_back('{c, r, cv, m, cr, e, ret, pf, fl, rd, g, dn, id, ov});
   endtask
   task automatic cmp(input int row, input string name, input logic [3:0] act, exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL row %0d %s: got %b expected %b", row, name, act, exp);
      end
   endtask
   initial begin
      logic [3:0] rot [4];
      rot[0] = 4'd1; rot[1] = 4'd2; rot[2] = 4'd4; rot[3] = 4'd8;
      // all lanes, 2 credits: strict rotation, then drain by bulk returns
      add(0,1,0,0,0,1,0,0,0, 0,0,0,0,0);
      add(1,0,1,4'hf,2,0,0,0,0, 0,0,0,1,0);
      add(1,0,0,0,0,0,0,0,0, 0,0,0,0,0);
      for (int i = 0; i < 8; i++) add(1,0,0,0,0,0,0,0,0, 1,rot[i%4],1,0,0);
      add(1,0,0,0,0,0,0,0,1, 0,0,1,0,0);
      add(1,0,0,0,0,0,4'hf,0,0, 0,0,0,0,0);
      add(1,0,0,0,0,0,4'hf,0,0, 0,0,0,0,0);
      add(1,0,0,0,0,0,0,0,0, 0,0,0,0,0);
      add(1,0,0,0,0,1,0,0,0, 0,0,0,1,0);
      // prog_full on lane 1 with one cycle of lag
      add(0,1,0,0,0,1,0,0,0, 0,0,0,0,0);
      add(1,0,1,4'hf,2,1,0,0,0, 0,0,0,1,0);
      add(1,0,0,0,0,1,0,0,0, 0,0,0,0,0);
      add(1,0,0,0,0,0,0,2,0, 1,1,1,0,0);
      add(1,0,0,0,0,0,0,2,0, 1,4,1,0,0);
      add(1,0,0,0,0,0,0,2,0, 1,8,1,0,0);
      add(1,0,0,0,0,0,0,2,0, 1,1,1,0,0);
      add(1,0,0,0,0,0,0,2,0, 1,4,1,0,0);
      add(1,0,0,0,0,0,0,2,0, 1,8,1,0,0);
      add(1,0,0,0,0,0,0,2,0, 0,0,1,0,0);
      add(1,0,0,0,0,0,0,0,0, 0,0,1,0,0);
      add(1,0,0,0,0,0,0,0,0, 1,2,1,0,0);
      add(1,0,0,0,0,0,0,0,0, 1,2,1,0,0);
      add(1,0,0,0,0,0,0,0,0, 0,0,1,0,0);
      // mask 0101, grant+return net zero, spread drain, returns in IDLE
      add(0,1,0,0,0,1,0,0,0, 0,0,0,0,0);
      add(1,0,1,4'h5,1,1,0,0,0, 0,0,0,1,0);
      add(1,0,0,0,0,1,0,0,0, 0,0,0,0,0);
      add(1,0,0,0,0,0,1,0,0, 1,1,1,0,0);
      add(1,0,0,0,0,0,0,0,0, 1,4,1,0,0);
      add(1,0,0,0,0,0,0,0,0, 1,1,1,0,0);
      add(1,0,0,0,0,0,0,0,1, 0,0,1,0,0);
      add(1,0,0,0,0,0,0,0,0, 0,0,0,0,0);
      add(1,0,0,0,0,0,1,0,0, 0,0,0,0,0);
      add(1,0,0,0,0,0,0,0,0, 0,0,0,0,0);
      add(1,0,0,0,0,0,4,0,0, 0,0,0,0,0);
      add(1,0,0,0,0,0,0,0,0, 0,0,0,0,0);
      add(1,0,0,0,0,0,0,0,1, 0,0,0,1,0);
      add(1,0,0,0,0,1,1,0,0, 0,0,0,1,0);
      add(1,0,0,0,0,1,0,0,0, 0,0,0,1,1);
      // overflow at credit_init, reconfigure ignored in RUN, reset mid-RUN, clamp 15 -> 8
      add(0,1,0,0,0,1,0,0,0, 0,0,0,0,0);
      add(1,0,1,4'hf,3,1,0,0,0, 0,0,0,1,0);
      add(1,0,0,0,0,1,0,0,0, 0,0,0,0,0);
      add(1,0,0,0,0,1,4,0,0, 0,0,1,0,0);
      add(1,0,0,0,0,0,0,0,0, 1,1,1,0,1);
      add(1,0,0,0,0,0,0,0,0, 1,2,1,0,1);
      add(1,0,1,0,0,0,0,0,0, 1,4,1,0,1);
      add(1,1,0,0,0,0,0,0,0, 1,8,1,0,1);
      add(1,0,0,0,0,0,0,0,0, 0,0,0,1,0);
      add(1,0,1,4'h1,4'hf,0,0,0,0, 0,0,0,1,0);
      add(1,0,0,0,0,0,0,0,0, 0,0,0,0,0);
      for (int i = 0; i < 8; i++) add(1,0,0,0,0,0,0,0,0, 1,1,1,0,0);
      add(1,0,0,0,0,0,0,0,0, 0,0,1,0,0);
      // zero credits, then empty mask: no grants, immediate drain
      add(0,1,0,0,0,1,0,0,0, 0,0,0,0,0);
      add(1,0,1,4'hf,0,0,0,0,0, 0,0,0,1,0);
      add(1,0,0,0,0,0,0,0,0, 0,0,0,0,0);
      add(1,0,0,0,0,0,0,0,0, 0,0,1,0,0);
      add(1,0,0,0,0,0,0,0,1, 0,0,1,0,0);
      add(1,0,0,0,0,0,0,0,0, 0,0,0,0,0);
      add(1,0,1,4'h0,5,0,0,0,0, 0,0,0,1,0);
      add(1,0,0,0,0,0,0,0,0, 0,0,0,0,0);
      add(1,0,0,0,0,0,0,0,1, 0,0,1,0,0);
      add(1,0,0,0,0,0,0,0,0, 0,0,0,0,0);
      add(1,0,0,0,0,0,0,0,0, 0,0,0,1,0);
      foreach (vecs[i]) begin
         @(negedge ap_clk);
         areset = vecs[i].rst;
         configure_route_valid = vecs[i].cv;
         configure_lane_mask = vecs[i].mask;
         configure_credits = vecs[i].cred;
         fifo_response_engine_empty = vecs[i].emp;
         lane_credit_return = vecs[i].ret;
         lane_prog_full = vecs[i].pf;
         flush = vecs[i].fl;
         #1;
         if (vecs[i].chk) begin
            cmp(i, "rd_en", {3'b0, fifo_response_engine_rd_en}, {3'b0, vecs[i].rd});
            cmp(i, "grant_lane", grant_lane, vecs[i].gnt);
            cmp(i, "configure_done", {3'b0, configure_done}, {3'b0, vecs[i].dn});
            cmp(i, "idle", {3'b0, idle}, {3'b0, vecs[i].id});
            cmp(i, "credit_overflow", {3'b0, credit_overflow}, {3'b0, vecs[i].ov});
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
